fpu_pcpi_sched: RTL and testbench

PCPI-side controller that decodes single-precision OP-FP instructions from the core and issues each one to a shared floating-point adder or multiplier. It sequences one operation at a time, collects the result, and drives the PCPI wait/ready/write handshake back to the core. A watchdog keeps the core from hanging on a unit that never returns a result.

---
 rtl/fpu_pcpi_sched_if.sv | 46 ++++
 rtl/fpu_pcpi_sched.sv | 198 +++++++++++++++++++
 tb/tb_fpu_pcpi_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_pcpi_sched_if.sv
// fpu_pcpi_sched_if: groups the PCPI core handshake and the shared adder/multiplier handshake.
// Latency: none (wires only).
// Backpressure: none; the core is held off by pcpiWaitOut, and the units have no ready signal.
// Ports: slave = scheduler side, master = core + arithmetic units side.
interface fpu_pcpi_sched_if #(
  parameter int DATA_WIDTH = 32
);
  // core -> scheduler
  logic                  pcpiValidIn;
  logic [31:0]           pcpiInstIn;
  logic [DATA_WIDTH-1:0] pcpiRs1In;
  logic [DATA_WIDTH-1:0] pcpiRs2In;
  // scheduler -> core
  logic                  pcpiWrOut;
  logic [DATA_WIDTH-1:0] pcpiRdOut;
  logic                  pcpiWaitOut;
  logic                  pcpiReadyOut;
  // scheduler -> units
  logic [DATA_WIDTH-1:0] opADataOut;
  logic [DATA_WIDTH-1:0] opBDataOut;
  logic                  addValidOut;
  logic                  mulValidOut;
  // units -> scheduler
  logic                  addValidIn;
  logic [DATA_WIDTH-1:0] addDataIn;
  logic                  mulValidIn;
  logic [DATA_WIDTH-1:0] mulDataIn;
  // status
  logic                  timeoutOut;

  modport slave (
    input  pcpiValidIn, pcpiInstIn, pcpiRs1In, pcpiRs2In,
    input  addValidIn, addDataIn, mulValidIn, mulDataIn,
    output pcpiWrOut, pcpiRdOut, pcpiWaitOut, pcpiReadyOut,
    output opADataOut, opBDataOut, addValidOut, mulValidOut,
    output timeoutOut
  );

  modport master (
    output pcpiValidIn, pcpiInstIn, pcpiRs1In, pcpiRs2In,
    output addValidIn, addDataIn, mulValidIn, mulDataIn,
    input  pcpiWrOut, pcpiRdOut, pcpiWaitOut, pcpiReadyOut,
    input  opADataOut, opBDataOut, addValidOut, mulValidOut,
    input  timeoutOut
  );
endinterface

// File: rtl/fpu_pcpi_sched.sv
// fpu_pcpi_sched: decodes OP-FP fadd.s/fmul.s from PCPI and runs one op at a time on a shared adder or multiplier.
// Latency: unit start pulse 1 cycle after match; ready/wr 1 cycle after unit result valid, or after TIMEOUT_CYCLES busy cycles.
// Backpressure: core is stalled via pcpiWaitOut until the one-cycle ready pulse; units cannot stall the scheduler.
// Optional feature macro: FPU_SUB_EN -- when defined, fsub.s is also claimed and sent to the adder with rs2's sign flipped.
// Ports: clkIn (rising edge), rstLowIn (async, active-low); all handshake/data signals through fpu_pcpi_sched_if.slave:
//   pcpi* = core instruction/result handshake, op*/add*/mul* = shared unit operands, start pulses and results,
//   timeoutOut = sticky watchdog flag.
module fpu_pcpi_sched #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    TIMEOUT_CYCLES = 64,
  parameter logic [DATA_WIDTH-1:0] NAN_VALUE      = DATA_WIDTH'(32'h7FC00000)
) (
  input logic             clkIn,
  input logic             rstLowIn,
  fpu_pcpi_sched_if.slave bus
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_RESP,
    S_GAP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_sel_mul;
  logic                  r_abort;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_opa;
  logic [DATA_WIDTH-1:0] r_opb;
  logic [DATA_WIDTH-1:0] r_rd;
  logic                  r_wait;
  logic                  r_timeout;

  // ---------------- combinational decode ----------------
  logic [6:0]            w_funct7;
  logic                  w_is_opfp;
  logic                  w_is_add;
  logic                  w_is_mul;
  logic                  w_is_sub;
  logic                  w_match;
  logic [DATA_WIDTH-1:0] w_opb_in;
  logic                  w_unused_inst;

  assign w_funct7  = bus.pcpiInstIn[31:25];
  assign w_is_opfp = (bus.pcpiInstIn[6:0] == 7'b1010011);
  assign w_is_add  = (w_funct7 == 7'b0000000);
  assign w_is_mul  = (w_funct7 == 7'b0001000);
`ifdef FPU_SUB_EN
  assign w_is_sub  = (w_funct7 == 7'b0000100);
  // a - b is issued to the adder as a + (-b)
  assign w_opb_in  = w_is_sub ? {~bus.pcpiRs2In[DATA_WIDTH-1], bus.pcpiRs2In[DATA_WIDTH-2:0]} : bus.pcpiRs2In;
`else
  assign w_is_sub  = 1'b0;
  assign w_opb_in  = bus.pcpiRs2In;
`endif
  assign w_match   = bus.pcpiValidIn && w_is_opfp && (w_is_add || w_is_mul || w_is_sub);

  // register fields and rm are irrelevant to the scheduler
  assign w_unused_inst = ^bus.pcpiInstIn[24:7];

  // ---------------- FSM ----------------
  logic w_unit_vld;
  logic w_aborting;
  logic w_load;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_done_ok;
  logic w_done_to;
  logic w_abort_set;
  logic w_abort_clr;
  logic w_add_vld;
  logic w_mul_vld;
  logic w_resp;

  // only the selected unit's valid is listened to
  assign w_unit_vld = r_sel_mul ? bus.mulValidIn : bus.addValidIn;
  // an op whose core request vanished this cycle must not answer either
  assign w_aborting = r_abort || !bus.pcpiValidIn;

  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    w_done_ok   = 1'b0;
    w_done_to   = 1'b0;
    w_abort_set = 1'b0;
    w_abort_clr = 1'b0;
    w_add_vld   = 1'b0;
    w_mul_vld   = 1'b0;
    w_resp      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_abort_clr = 1'b1;
        if (w_match) begin
          w_load      = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_add_vld   = !r_sel_mul;
        w_mul_vld   = r_sel_mul;
        w_cnt_clr   = 1'b1;
        w_abort_set = !bus.pcpiValidIn;
        w_state_nxt = S_BUSY;
      end
      S_BUSY: begin
        w_abort_set = !bus.pcpiValidIn;
        // an aborted op still waits for its result so it cannot leak into the next op
        if (w_unit_vld) begin
          w_done_ok   = !w_aborting;
          w_state_nxt = w_aborting ? S_GAP : S_RESP;
        end else if (r_cnt == CNT_LAST) begin
          w_done_to   = !w_aborting;
          w_state_nxt = w_aborting ? S_GAP : S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        w_resp      = 1'b1;
        w_state_nxt = S_GAP;
      end
      S_GAP: begin
        // the finished instruction's valid may still be high here; ignore it
        w_abort_clr = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clkIn or negedge rstLowIn) begin
    if (!rstLowIn) begin
      r_sel_mul <= 1'b0;
      r_abort   <= 1'b0;
      r_cnt     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_rd      <= '0;
      r_wait    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_load) begin
        r_opa     <= bus.pcpiRs1In;
        r_opb     <= w_opb_in;
        r_sel_mul <= w_is_mul;
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_abort_clr) begin
        r_abort <= 1'b0;
      end else if (w_abort_set) begin
        r_abort <= 1'b1;
      end
      if (w_done_ok) begin
        r_rd <= r_sel_mul ? bus.mulDataIn : bus.addDataIn;
      end else if (w_done_to) begin
        r_rd <= NAN_VALUE;
      end
      if (w_done_to) begin
        r_timeout <= 1'b1;
      end
      r_wait <= (w_state_nxt == S_ISSUE) || (w_state_nxt == S_BUSY);
    end
  end

  assign bus.opADataOut   = r_opa;
  assign bus.opBDataOut   = r_opb;
  assign bus.addValidOut  = w_add_vld;
  assign bus.mulValidOut  = w_mul_vld;
  assign bus.pcpiWaitOut  = r_wait;
  assign bus.pcpiReadyOut = w_resp;
  assign bus.pcpiWrOut    = w_resp;
  assign bus.pcpiRdOut    = r_rd;
  assign bus.timeoutOut   = r_timeout;

endmodule

// File: tb/tb_fpu_pcpi_sched.sv
`timescale 1ns/1ps
module tb_fpu_pcpi_sched;
  localparam int          DW  = 32;
  localparam int          TMO = 64;
  localparam logic [31:0] NAN = 32'h7FC00000;

  logic clkIn = 1'b0;
  logic rstLowIn;
  always #5 clkIn = ~clkIn;

  fpu_pcpi_sched_if #(.DATA_WIDTH(DW)) bus ();

  fpu_pcpi_sched #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .NAN_VALUE(NAN)) dut (
    .clkIn(clkIn),
    .rstLowIn(rstLowIn),
    .bus(bus)
  );

  typedef struct {
    logic        is_mul;
    logic [31:0] opa;
    logic [31:0] opb;
    int          lat;   // 0 = unit never answers
    logic [31:0] data;
  } iss_t;

  typedef struct {
    logic [31:0] rd;
    int          cyc;
    int          waitc;
    logic        to;
  } rsp_t;

  iss_t iss_q[$];
  rsp_t rsp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_ready  = 0;
  int   cyc      = 0;
  bit   idle_chk = 1'b0;
  bit   model_to = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clkIn) cyc <= cyc + 1;

  // reference decode: 0 none, 1 fadd, 2 fmul, 3 fsub
  function automatic int ref_decode(input logic [31:0] inst);
    logic [6:0] op;
    logic [6:0] f7;
    op = inst[6:0];
    f7 = inst[31:25];
    if (op != 7'h53) return 0;
    case (f7)
      7'h00: return 1;
      7'h08: return 2;
`ifdef FPU_SUB_EN
      7'h04: return 3;
`endif
      default: return 0;
    endcase
  endfunction

  // ---------------- core-side monitor ----------------
  int   wcnt = 0;
  logic prev_wait = 1'b0;
  rsp_t mon_e;
  always @(negedge clkIn) begin
    if (rstLowIn) begin
      if (bus.pcpiWaitOut) wcnt = prev_wait ? wcnt + 1 : 1;
      prev_wait = bus.pcpiWaitOut;
      if (bus.pcpiReadyOut) begin
        n_ready++;
        if (rsp_q.size() == 0) begin
          check("unexpected_ready", {31'b0, bus.pcpiReadyOut}, 32'd0);
        end else begin
          mon_e = rsp_q.pop_front();
          check("rd", bus.pcpiRdOut, mon_e.rd);
          check("wr", {31'b0, bus.pcpiWrOut}, 32'd1);
          check("ready_cycle", 32'(cyc), 32'(mon_e.cyc));
          check("wait_cycles", 32'(wcnt), 32'(mon_e.waitc));
          check("timeout_flag", {31'b0, bus.timeoutOut}, {31'b0, mon_e.to});
        end
      end
      if (idle_chk) begin
        check("idle_wait", {31'b0, bus.pcpiWaitOut}, 32'd0);
        check("idle_wr", {31'b0, bus.pcpiWrOut}, 32'd0);
      end
    end else begin
      prev_wait = 1'b0;
    end
  end

  // ---------------- unit responder ----------------
  iss_t rsp_e;
  initial begin
    bus.addValidIn = 1'b0;
    bus.addDataIn  = '0;
    bus.mulValidIn = 1'b0;
    bus.mulDataIn  = '0;
    forever begin
      @(negedge clkIn);
      if (rstLowIn && (bus.addValidOut || bus.mulValidOut)) begin
        check("one_start", {31'b0, bus.addValidOut & bus.mulValidOut}, 32'd0);
        if (iss_q.size() == 0) begin
          check("unexpected_start", {31'b0, bus.addValidOut | bus.mulValidOut}, 32'd0);
        end else begin
          rsp_e = iss_q.pop_front();
          check("start_is_mul", {31'b0, bus.mulValidOut}, {31'b0, rsp_e.is_mul});
          check("opA", bus.opADataOut, rsp_e.opa);
          check("opB", bus.opBDataOut, rsp_e.opb);
          if (rsp_e.lat > 0) begin
            // the other unit answers first with junk, which must be ignored
            repeat (rsp_e.lat - 1) @(posedge clkIn);
            #1;
            if (rsp_e.is_mul) begin bus.addValidIn = 1'b1; bus.addDataIn = ~rsp_e.data; end
            else              begin bus.mulValidIn = 1'b1; bus.mulDataIn = ~rsp_e.data; end
            @(posedge clkIn);
            #1;
            bus.addValidIn = 1'b0;
            bus.mulValidIn = 1'b0;
            if (rsp_e.is_mul) begin bus.mulValidIn = 1'b1; bus.mulDataIn = rsp_e.data; end
            else              begin bus.addValidIn = 1'b1; bus.addDataIn = rsp_e.data; end
            @(posedge clkIn);
            #1;
            bus.addValidIn = 1'b0;
            bus.mulValidIn = 1'b0;
          end else begin
            repeat (5) @(posedge clkIn);
            #1;
            if (rsp_e.is_mul) bus.addValidIn = 1'b1;
            else              bus.mulValidIn = 1'b1;
            @(posedge clkIn);
            #1;
            bus.addValidIn = 1'b0;
            bus.mulValidIn = 1'b0;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic run_op(input logic [31:0] inst, input logic [31:0] rs1, input logic [31:0] rs2,
                        input int lat, input logic [31:0] data, input int hold);
    int   kind;
    int   base;
    int   k;
    int   eff;
    iss_t ie;
    rsp_t re;
    kind = ref_decode(inst);
    bus.pcpiInstIn = inst;
    bus.pcpiRs1In  = rs1;
    bus.pcpiRs2In  = rs2;
    base = n_ready;
    if (kind == 0) begin
      idle_chk = 1'b1;
      bus.pcpiValidIn = 1'b1;
      repeat (hold) @(posedge clkIn);
      #1;
      bus.pcpiValidIn = 1'b0;
      idle_chk = 1'b0;
      check("no_claim_ready", 32'(n_ready), 32'(base));
    end else begin
      eff       = (lat == 0) ? TMO : lat;
      ie.is_mul = (kind == 2);
      ie.opa    = rs1;
      ie.opb    = (kind == 3) ? (rs2 ^ 32'h80000000) : rs2;
      ie.lat    = lat;
      ie.data   = data;
      if (lat == 0) model_to = 1'b1;
      re.rd    = (lat == 0) ? NAN : data;
      re.cyc   = cyc + 2 + eff;
      re.waitc = 1 + eff;
      re.to    = model_to;
      iss_q.push_back(ie);
      rsp_q.push_back(re);
      bus.pcpiValidIn = 1'b1;
      k = 0;
      while (n_ready == base && k < 200) begin
        @(posedge clkIn);
        k++;
      end
      if (n_ready == base) begin
        check("ready_timeout", 32'(n_ready), 32'(base + 1));
        iss_q.delete();
        rsp_q.delete();
      end
      // keep valid high across the GAP-ending edge
      @(posedge clkIn);
      #1;
      bus.pcpiValidIn = 1'b0;
      @(posedge clkIn);
      #1;
    end
  endtask

  task automatic run_abort(input logic [31:0] inst, input int lat, input int drop_after);
    iss_t ie;
    int   base;
    ie.is_mul = (ref_decode(inst) == 2);
    ie.opa    = $urandom;
    ie.opb    = $urandom;
    ie.lat    = lat;
    ie.data   = $urandom;
    iss_q.push_back(ie);
    bus.pcpiInstIn  = inst;
    bus.pcpiRs1In   = ie.opa;
    bus.pcpiRs2In   = ie.opb;
    base = n_ready;
    bus.pcpiValidIn = 1'b1;
    repeat (drop_after) @(posedge clkIn);
    #1;
    bus.pcpiValidIn = 1'b0;
    repeat (((lat == 0) ? TMO : lat) + 6) @(posedge clkIn);
    #1;
    check("abort_no_ready", 32'(n_ready), 32'(base));
    check("abort_no_timeout", {31'b0, bus.timeoutOut}, {31'b0, model_to});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wait"},  {31'b0, bus.pcpiWaitOut},  32'd0);
    check({tag, "_ready"}, {31'b0, bus.pcpiReadyOut}, 32'd0);
    check({tag, "_wr"},    {31'b0, bus.pcpiWrOut},    32'd0);
    check({tag, "_rd"},    bus.pcpiRdOut,             32'd0);
    check({tag, "_opA"},   bus.opADataOut,            32'd0);
    check({tag, "_opB"},   bus.opBDataOut,            32'd0);
    check({tag, "_addv"},  {31'b0, bus.addValidOut},  32'd0);
    check({tag, "_mulv"},  {31'b0, bus.mulValidOut},  32'd0);
    check({tag, "_to"},    {31'b0, bus.timeoutOut},   32'd0);
  endtask

  task automatic run_reset_mid();
    iss_t ie;
    int   base;
    ie.is_mul = 1'b1;
    ie.opa    = 32'h40000000;
    ie.opb    = 32'h40400000;
    ie.lat    = 10;
    ie.data   = 32'h12345678;
    iss_q.push_back(ie);
    bus.pcpiInstIn  = 32'h103100D3;
    bus.pcpiRs1In   = ie.opa;
    bus.pcpiRs2In   = ie.opb;
    bus.pcpiValidIn = 1'b1;
    repeat (4) @(posedge clkIn);
    #1;
    rstLowIn = 1'b0;
    #1;
    check_all_zero("midrst");
    model_to = 1'b0;
    bus.pcpiValidIn = 1'b0;
    @(posedge clkIn);
    #1;
    rstLowIn = 1'b1;
    base = n_ready;
    repeat (15) @(posedge clkIn);
    #1;
    check("late_result_dropped", 32'(n_ready), 32'(base));
  endtask

  logic [31:0] r_inst;
  int          r_kind;
  initial begin
    rstLowIn        = 1'b0;
    bus.pcpiValidIn = 1'b0;
    bus.pcpiInstIn  = '0;
    bus.pcpiRs1In   = '0;
    bus.pcpiRs2In   = '0;
    repeat (3) @(posedge clkIn);
    #1;
    check_all_zero("reset");
    rstLowIn = 1'b1;
    @(posedge clkIn);
    #1;

    run_op(32'h103100D3, 32'h40000000, 32'h40400000, 4, 32'h40C00000, 0);   // fmul 2*3
    run_op(32'h003100D3, 32'h3F800000, 32'h3F800000, 3, 32'h40000000, 0);   // fadd 1+1
    run_op(32'h003100B3, 32'h11111111, 32'h22222222, 0, 32'h0, 20);          // integer add, not claimed
    run_op(32'h083100D3, 32'h40400000, 32'h3F800000, 2, 32'h40000000, 20);   // fsub 3-1
    run_abort(32'h003100D3, 8, 3);
    run_abort(32'h103100D3, 0, 3);
    run_op(32'h103100D3, 32'h40000000, 32'h40400000, 0, 32'h0, 0);           // multiplier never answers
    run_op(32'h003100D3, 32'h3F800000, 32'h3F800000, 1, 32'h40000000, 0);   // timeout flag stays set

    for (int i = 0; i < 30; i++) begin
      r_kind = $urandom_range(0, 4);
      r_inst = $urandom;
      case (r_kind)
        0: r_inst = {7'h00, r_inst[24:7], 7'h53};
        1: r_inst = {7'h08, r_inst[24:7], 7'h53};
        2: r_inst = {7'h04, r_inst[24:7], 7'h53};
        3: r_inst = {r_inst[31:7], 7'h53};
        default: r_inst = {r_inst[31:7], 7'h33};
      endcase
      run_op(r_inst, $urandom, $urandom, $urandom_range(1, 8), $urandom, 4);
    end

    run_reset_mid();
    run_op(32'h003100D3, 32'h3F800000, 32'h40000000, 2, 32'h40400000, 0);   // normal after reset

    check("iss_q_empty", 32'(iss_q.size()), 32'd0);
    check("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
